md_result_drain: RTL and testbench
==================================

Name: md_result_drain

Overview:
- Sits directly downstream of MD_Wrapper. After a simulation timestep it pulls every particle result out of the core, buffers the results, and streams them out on a valid/ready interface.
- Generates MD_Wrapper's `read_ctrl` request pulses and captures `d_out` on each `elem_read` strobe.
- Advances the core's `step` input once a full frame has been drained, replacing the hand-driven readout sequence.

Parameters:
- NUM_PARTICLES, 300: result words per frame.
- DATA_W, 192: width of MD_Wrapper `d_out` and of `m_tdata`.
- PULSE_CYCLES, 16: ap_clk cycles `md_read_ctrl` is held high per request.
- GAP_CYCLES, 46: minimum low cycles between requests.
- FIFO_DEPTH, 4: output buffer entries; power of 2, at least 2.
- TIMEOUT, 1024: cycles allowed from request start to `elem_read`.

Ports:
- ap_clk  in  1  sole clock.
- ap_rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a frame drain; ignored unless IDLE.
- md_read_ctrl  out  1  to MD_Wrapper `read_ctrl`.
- md_elem_read  in  1  from MD_Wrapper `elem_read`; one-cycle strobe, `md_d_out` valid in the same cycle.
- md_d_out  in  DATA_W  from MD_Wrapper `d_out`.
- md_step  out  32  to MD_Wrapper `step`.
- m_tdata  out  DATA_W  output data.
- m_tvalid  out  1  output valid.
- m_tready  in  1  downstream ready.
- m_tlast  out  1  high with the NUM_PARTICLES-th word of a frame.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a frame completes.
- err_timeout  out  1  sticky; cleared by reset or `start`.
- count  out  16  words captured in the current frame.

Behaviour:
- Reset values: every output is 0 (including `md_step` and `count`); FIFO is empty; FSM is IDLE.
- FSM states:
  - IDLE: on `start`, clear `count` and `err_timeout`, go to REQ.
  - REQ: `md_read_ctrl`=1 for exactly PULSE_CYCLES cycles, then go to WAIT. The timeout counter starts at REQ entry.
  - WAIT: `md_read_ctrl`=0.
    - On `md_elem_read` (also accepted during REQ): write `md_d_out` to the FIFO, increment `count`, go to GAP.
    - If the timeout counter reaches TIMEOUT: set `err_timeout`, go to FLUSH.
  - GAP: wait GAP_CYCLES cycles.
    - If `count`==NUM_PARTICLES, go to FLUSH.
    - Else if FIFO occupancy + 1 < FIFO_DEPTH (a free slot beyond the word just captured), go to REQ.
    - Else stay in GAP until that holds (credit stall).
  - FLUSH: wait for the FIFO to empty, then go to DONE.
  - DONE: pulse `done` for 1 cycle. Increment `md_step` by 1 only if `err_timeout`==0. Return to IDLE.
- A request is issued only when a FIFO slot is guaranteed free, so the FIFO never overflows.
- Spurious `md_elem_read` in IDLE, GAP or FLUSH is ignored: no write, no count change.
- FIFO output:
  - `m_tvalid` = FIFO not empty; `m_tdata` = head entry; pop when `m_tvalid && m_tready`.
  - Push and pop in the same cycle: occupancy is unchanged, no data lost.
  - Write-to-`m_tvalid` latency is 1 cycle (registered write pointer).
  - `m_tdata` must not change while `m_tvalid && !m_tready`.
- `m_tlast` = head entry's tag bit; the tag is set on the capture where `count` becomes NUM_PARTICLES.
- `count` saturates at NUM_PARTICLES. `md_step` wraps 0xFFFFFFFF -> 0.
- Reset asserted mid-frame returns the block to reset values on the next edge. FIFO contents are discarded and `md_read_ctrl` drops immediately.
- `start` while busy is ignored.

Optional Feature:
- MD_DRAIN_CHECKSUM_EN.
- Defined: adds output port `frame_csum` [31:0].
  - XOR-fold of each captured word's 32-bit slices, accumulated across the frame.
  - Cleared on `start` and reset; stable from the `done` pulse until the next `start`.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
- NUM_PARTICLES=300, `m_tready`=1, core model answers `elem_read` 3 cycles after each `read_ctrl` rise -> 300 words in order; `m_tlast` only on word 300; `done` pulses once; `md_step` 0->1; 300 `read_ctrl` pulses, each exactly 16 cycles high and at least 46 low.
- `m_tready`=0 for 500 cycles mid-frame, FIFO_DEPTH=4 -> at most 3 outstanding captures, `read_ctrl` held low, `m_tdata` stable; after release all 300 words arrive, none lost or duplicated.
- Core never asserts `elem_read` on word 5, TIMEOUT=1024 -> `err_timeout`=1 at cycle 1024 after that request; words 1-4 flushed; `done` pulses; `md_step` unchanged.
- `ap_rst_n` low for 1 cycle during word 150 -> all outputs 0 on the next edge; a fresh `start` drains 300 words correctly.
- Spurious `elem_read` in IDLE and GAP, plus `start` asserted while busy -> `count`, FIFO and FSM unaffected.
- MD_DRAIN_CHECKSUM_EN defined, words k=0..299 with every 32-bit slice = k -> `frame_csum` equals the XOR over k of (k XOR-folded over DATA_W/32=6 slices) = 0.

Source files
------------

// File: rtl/md_result_drain.sv
// md_result_drain: pulls one frame of particle results out of MD_Wrapper,
// buffers them in a small FIFO and streams them out on a valid/ready port.
// Issues one read_ctrl request per word, only when a FIFO slot is guaranteed
// free, and advances md_step once a frame has been drained cleanly.
// Optional build macro: MD_DRAIN_CHECKSUM_EN adds the frame_csum output.
//
// Output handshake: a word moves on every ap_clk edge where m_tvalid and
// m_tready are both high; m_tvalid never drops and m_tdata/m_tlast never
// change while a word is waiting for m_tready.

module md_result_drain #(
    parameter int unsigned NUM_PARTICLES = 300,
    parameter int unsigned DATA_W        = 192,
    parameter int unsigned PULSE_CYCLES  = 16,
    parameter int unsigned GAP_CYCLES    = 46,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned TIMEOUT       = 1024
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              start,
    output logic              md_read_ctrl,
    input  logic              md_elem_read,
    input  logic [DATA_W-1:0] md_d_out,
    output logic [31:0]       md_step,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic [15:0]       count
`ifdef MD_DRAIN_CHECKSUM_EN
    ,
    output logic [31:0]       frame_csum
`endif
);

    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam logic [15:0] NUM_W     = 16'(NUM_PARTICLES);
    localparam logic [AW:0] OCC_LIMIT = (AW + 1)'(FIFO_DEPTH - 1);
    localparam logic [AW:0] PTR_ONE   = (AW + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_GAP   = 3'd3,
        S_FLUSH = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] tmr_q, tmr_d;       // pulse length / gap length counter
    logic [31:0] to_q, to_d;         // cycles since the current request started
    logic        got_q, got_d;       // word already captured during this REQ pulse
    logic        rc_q, rc_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] step_q, step_d;
    logic [15:0] count_q, count_d;

    logic [AW:0]     wr_q, wr_d, rd_q, rd_d;
    logic [DATA_W:0] mem_q [FIFO_DEPTH];  // {tlast tag, data}
    logic [DATA_W:0] head;
    logic [AW:0]     occ;
    logic            fifo_empty;
    logic            push, pop;
    logic            cap_last;

    assign fifo_empty = (wr_q == rd_q);
    assign occ        = wr_q - rd_q;
    assign head       = mem_q[rd_q[AW-1:0]];
    assign cap_last   = ((count_q + 16'd1) == NUM_W);

    // Frame sequencing: request pulses, capture, gap/credit stall, flush, done.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        to_d    = to_q;
        got_d   = got_q;
        rc_d    = rc_q;
        done_d  = 1'b0;
        err_d   = err_q;
        step_d  = step_q;
        count_d = count_q;
        push    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    count_d = '0;
                    err_d   = 1'b0;
                    state_d = S_REQ;
                    rc_d    = 1'b1;
                    tmr_d   = '0;
                    to_d    = '0;
                    got_d   = 1'b0;
                end
            end
            S_REQ: begin
                tmr_d = tmr_q + 32'd1;
                to_d  = to_q + 32'd1;
                // An early answer is taken now, but the pulse still runs full length.
                if (md_elem_read && !got_q) begin
                    push    = 1'b1;
                    got_d   = 1'b1;
                    count_d = (count_q == NUM_W) ? count_q : count_q + 16'd1;
                end
                if (tmr_q == PULSE_CYCLES - 1) begin
                    rc_d    = 1'b0;
                    tmr_d   = '0;
                    state_d = (got_q || md_elem_read) ? S_GAP : S_WAIT;
                end
            end
            S_WAIT: begin
                to_d = to_q + 32'd1;
                if (md_elem_read) begin
                    push    = 1'b1;
                    count_d = (count_q == NUM_W) ? count_q : count_q + 16'd1;
                    tmr_d   = '0;
                    state_d = S_GAP;
                end else if (to_q == TIMEOUT - 1) begin
                    err_d   = 1'b1;
                    state_d = S_FLUSH;
                end
            end
            S_GAP: begin
                // Counter parks on its last value while waiting for FIFO credit.
                if (tmr_q != GAP_CYCLES - 1) begin
                    tmr_d = tmr_q + 32'd1;
                end else if (count_q == NUM_W) begin
                    state_d = S_FLUSH;
                end else if (occ < OCC_LIMIT) begin
                    state_d = S_REQ;
                    rc_d    = 1'b1;
                    tmr_d   = '0;
                    to_d    = '0;
                    got_d   = 1'b0;
                end
            end
            S_FLUSH: begin
                if (fifo_empty) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    step_d  = err_q ? step_q : step_q + 32'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // FIFO pointer update; a simultaneous push and pop leaves occupancy unchanged.
    always_comb begin
        pop  = !fifo_empty && m_tready;
        wr_d = push ? wr_q + PTR_ONE : wr_q;
        rd_d = pop  ? rd_q + PTR_ONE : rd_q;
    end

    // FSM and FIFO pointer registers with synchronous active-low reset.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            to_q    <= '0;
            got_q   <= 1'b0;
            rc_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            step_q  <= '0;
            count_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            to_q    <= to_d;
            got_q   <= got_d;
            rc_q    <= rc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            step_q  <= step_d;
            count_q <= count_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    // FIFO storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge ap_clk) begin
        if (ap_rst_n && push) begin
            mem_q[wr_q[AW-1:0]] <= {cap_last, md_d_out};
        end
    end

    // read_ctrl is also gated by reset so it falls in the cycle reset is seen.
    assign md_read_ctrl = rc_q & ap_rst_n;
    assign md_step      = step_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_timeout  = err_q;
    assign count        = count_q;
    assign m_tvalid     = !fifo_empty;
    assign m_tdata      = fifo_empty ? '0 : head[DATA_W-1:0];
    assign m_tlast      = !fifo_empty && head[DATA_W];

`ifdef MD_DRAIN_CHECKSUM_EN
    localparam int unsigned NSLICE = (DATA_W + 31) / 32;

    logic [31:0]          csum_q, csum_d;
    logic [NSLICE*32-1:0] cap_pad;
    logic [31:0]          cap_fold;

    // XOR-fold each captured word into 32 bits and accumulate over the frame.
    always_comb begin
        cap_pad                = '0;
        cap_pad[DATA_W-1:0]    = md_d_out;
        cap_fold               = '0;
        for (int i = 0; i < int'(NSLICE); i++) begin
            cap_fold = cap_fold ^ cap_pad[i*32 +: 32];
        end
        csum_d = csum_q;
        if (state_q == S_IDLE && start) begin
            csum_d = '0;
        end else if (push) begin
            csum_d = csum_q ^ cap_fold;
        end
    end

    // Checksum register, held from the done pulse until the next start.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign frame_csum = csum_q;
`endif

endmodule

// File: tb/tb_md_result_drain.sv
// Directed bench for md_result_drain: normal frame, output backpressure,
// spurious strobes and start-while-busy, request timeout, mid-frame reset.
// A core model answers each read_ctrl rise 3 cycles later and queues the
// expected word; the output monitor pops and compares on each handshake.
`timescale 1ns/1ps

module tb_md_result_drain;

    localparam int NP    = 12;
    localparam int DW    = 192;
    localparam int PULSE = 16;
    localparam int GAP   = 46;
    localparam int DEPTH = 4;
    localparam int TMO   = 1024;

    logic          ap_clk   = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic          start    = 1'b0;
    logic          m_tready = 1'b1;
    logic          md_elem_read;
    logic [DW-1:0] md_d_out;
    logic          md_read_ctrl;
    logic [31:0]   md_step;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          busy;
    logic          done;
    logic          err_timeout;
    logic [15:0]   count;
`ifdef MD_DRAIN_CHECKSUM_EN
    logic [31:0]   frame_csum;
    logic [31:0]   exp_csum = '0;
`endif

    // Core model and spurious-strobe driver share the elem_read input.
    logic          model_er = 1'b0;
    logic [DW-1:0] model_d  = '0;
    logic          spur_er  = 1'b0;
    logic [DW-1:0] spur_d   = '1;
    assign md_elem_read = model_er | spur_er;
    assign md_d_out     = spur_er ? spur_d : model_d;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int word_idx      = 0;
    int frame_id      = 0;
    int skip_idx      = -1;
    int skip_rise_cyc = -1;
    int err_rise_cyc  = -1;
    int rx_cnt        = 0;
    int last_cnt      = 0;
    int done_cnt      = 0;
    logic [DW:0] exp_q[$];

    md_result_drain #(
        .NUM_PARTICLES(NP),
        .DATA_W       (DW),
        .PULSE_CYCLES (PULSE),
        .GAP_CYCLES   (GAP),
        .FIFO_DEPTH   (DEPTH),
        .TIMEOUT      (TMO)
    ) dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .start       (start),
        .md_read_ctrl(md_read_ctrl),
        .md_elem_read(md_elem_read),
        .md_d_out    (md_d_out),
        .md_step     (md_step),
        .m_tdata     (m_tdata),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tlast     (m_tlast),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout),
        .count       (count)
`ifdef MD_DRAIN_CHECKSUM_EN
        ,
        .frame_csum  (frame_csum)
`endif
    );

    // Clock and cycle counter
    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) cyc++;

    task automatic check(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_word(input int f, input int k);
        logic [DW-1:0] w;
        w = '0;
        for (int s = 0; s < DW / 32; s++) w[s*32 +: 32] = {8'(f), 8'(s), 16'(k)};
        return w;
    endfunction

`ifdef MD_DRAIN_CHECKSUM_EN
    function automatic logic [31:0] fold32(input logic [DW-1:0] w);
        logic [31:0] f;
        f = '0;
        for (int s = 0; s < DW / 32; s++) f = f ^ w[s*32 +: 32];
        return f;
    endfunction
`endif

    // Core model: answers each read_ctrl rise 3 cycles later unless told to skip.
    initial begin : core_model
        forever begin
            @(posedge md_read_ctrl);
            if (word_idx == skip_idx) begin
                skip_rise_cyc = cyc;
            end else begin
                repeat (3) @(posedge ap_clk);
                #1;
                model_d  = mk_word(frame_id, word_idx);
                model_er = 1'b1;
                exp_q.push_back({(word_idx == NP - 1), model_d});
`ifdef MD_DRAIN_CHECKSUM_EN
                exp_csum = exp_csum ^ fold32(model_d);
`endif
                check("outstanding_le_3", exp_q.size() <= DEPTH - 1, 1'b1);
                word_idx++;
                @(posedge ap_clk);
                #1;
                model_er = 1'b0;
            end
        end
    end

    // read_ctrl pulse shape: exactly PULSE high, at least GAP low between pulses.
    int  hi_len = 0;
    int  lo_len = 0;
    bit  seen_pulse = 1'b0;
    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            hi_len = 0;
            lo_len = 0;
            seen_pulse = 1'b0;
        end else if (md_read_ctrl) begin
            if (hi_len == 0 && seen_pulse) check("gap_low_min", lo_len >= GAP, 1'b1);
            hi_len++;
            lo_len = 0;
        end else begin
            if (hi_len != 0) begin
                check("pulse_high_len", hi_len, PULSE);
                seen_pulse = 1'b1;
            end
            hi_len = 0;
            lo_len++;
        end
    end

    // Output scoreboard, hold-stable check, done and err_timeout edge tracking.
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic          prev_err   = 1'b0;
    always @(negedge ap_clk) begin
        logic [DW:0] e;
        if (ap_rst_n) begin
            if (prev_stall) begin
                check("hold_valid", m_tvalid, 1'b1);
                check("hold_data", m_tdata, prev_data);
            end
            if (m_tvalid && m_tready) begin
                check("rx_expected_present", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("rx_data", m_tdata, e[DW-1:0]);
                    check("rx_last", m_tlast, e[DW]);
                end
                rx_cnt++;
                if (m_tlast) last_cnt++;
            end
            if (done) done_cnt++;
            if (err_timeout && !prev_err) err_rise_cyc = cyc;
        end
        prev_stall = ap_rst_n && m_tvalid && !m_tready;
        prev_data  = m_tdata;
        prev_err   = err_timeout;
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, "_read_ctrl"}, md_read_ctrl, 1'b0);
        check({tag, "_tvalid"}, m_tvalid, 1'b0);
        check({tag, "_tlast"}, m_tlast, 1'b0);
        check({tag, "_tdata"}, m_tdata, '0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_err"}, err_timeout, 1'b0);
        check({tag, "_step"}, md_step, 32'd0);
        check({tag, "_count"}, count, 16'd0);
    endtask

    task automatic start_frame();
        frame_id++;
        word_idx     = 0;
        rx_cnt       = 0;
        last_cnt     = 0;
        err_rise_cyc = -1;
`ifdef MD_DRAIN_CHECKSUM_EN
        exp_csum = '0;
`endif
        @(posedge ap_clk);
        #1 start = 1'b1;
        @(posedge ap_clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge ap_clk);
            n++;
        end
        check({tag, "_done_seen"}, done_cnt != d0, 1'b1);
        repeat (3) @(posedge ap_clk);
        #1;
        check({tag, "_done_once"}, done_cnt - d0, 1);
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic wait_words(input string tag, input int n);
        int k;
        k = 0;
        while (word_idx < n && k < 2000) begin
            @(posedge ap_clk);
            k++;
        end
        check({tag, "_words_reached"}, word_idx >= n, 1'b1);
    endtask

    task automatic pulse_spurious();
        @(posedge ap_clk);
        #1 spur_er = 1'b1;
        @(posedge ap_clk);
        #1 spur_er = 1'b0;
    endtask

    // Directed sequence
    initial begin : main
        int n;
        // Reset values
        ap_rst_n = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1;
        check_zero_outputs("reset");
        ap_rst_n = 1'b1;
        repeat (2) @(posedge ap_clk);

        // Frame 1: free-flowing output
        start_frame();
        #1 check("f1_busy", busy, 1'b1);
        wait_done("f1", 3000);
        check("f1_step", md_step, 32'd1);
        check("f1_count", count, 16'(NP));
        check("f1_err", err_timeout, 1'b0);
        check("f1_rx", rx_cnt, NP);
        check("f1_last", last_cnt, 1);
        check("f1_q_empty", exp_q.size(), 0);
`ifdef MD_DRAIN_CHECKSUM_EN
        check("f1_csum", frame_csum, exp_csum);
        check("f1_csum_const", frame_csum, 32'h0);
`endif

        // Frame 2: m_tready low for 500 cycles; only 3 words may be in flight
        m_tready = 1'b0;
        start_frame();
        repeat (500) @(posedge ap_clk);
        #1;
        check("f2_stall_count", count, 16'd3);
        check("f2_stall_inflight", exp_q.size(), 3);
        check("f2_stall_read_ctrl", md_read_ctrl, 1'b0);
        check("f2_stall_tvalid", m_tvalid, 1'b1);
        check("f2_stall_head", m_tdata, mk_word(frame_id, 0));
        check("f2_stall_busy", busy, 1'b1);
        m_tready = 1'b1;
        wait_done("f2", 3000);
        check("f2_step", md_step, 32'd2);
        check("f2_rx", rx_cnt, NP);
        check("f2_last", last_cnt, 1);
        check("f2_q_empty", exp_q.size(), 0);

        // Spurious elem_read in IDLE
        pulse_spurious();
        #1;
        check("idle_spur_count", count, 16'(NP));
        check("idle_spur_tvalid", m_tvalid, 1'b0);
        check("idle_spur_busy", busy, 1'b0);

        // Frame 3: spurious elem_read and start while in GAP
        start_frame();
        wait_words("f3", 1);
        repeat (20) @(posedge ap_clk);
        #1;
        check("f3_gap_read_ctrl", md_read_ctrl, 1'b0);
        check("f3_gap_count", count, 16'd1);
        spur_er = 1'b1;
        start   = 1'b1;
        @(posedge ap_clk);
        #1;
        spur_er = 1'b0;
        start   = 1'b0;
        repeat (2) @(posedge ap_clk);
        #1;
        check("f3_spur_count", count, 16'd1);
        check("f3_spur_tvalid", m_tvalid, 1'b0);
        check("f3_spur_busy", busy, 1'b1);
        wait_done("f3", 3000);
        check("f3_step", md_step, 32'd3);
        check("f3_rx", rx_cnt, NP);
        check("f3_last", last_cnt, 1);
        check("f3_count", count, 16'(NP));

        // Frame 4: core never answers word 5
        skip_idx = 4;
        start_frame();
        wait_done("f4", 3000);
        skip_idx = -1;
        check("f4_err", err_timeout, 1'b1);
        check("f4_err_latency", err_rise_cyc - skip_rise_cyc, TMO);
        check("f4_step_unchanged", md_step, 32'd3);
        check("f4_count", count, 16'd4);
        check("f4_rx", rx_cnt, 4);
        check("f4_last", last_cnt, 0);
`ifdef MD_DRAIN_CHECKSUM_EN
        check("f4_csum", frame_csum, exp_csum);
`endif

        // Frame 5: start clears err_timeout; reset mid-request
        start_frame();
        #1 check("f5_err_cleared", err_timeout, 1'b0);
        wait_words("f5", 6);
        n = 0;
        while (!md_read_ctrl && n < 200) begin
            @(posedge ap_clk);
            #1;
            n++;
        end
        check("f5_req_seen", md_read_ctrl, 1'b1);
        ap_rst_n = 1'b0;
        #1 check("f5_read_ctrl_drop", md_read_ctrl, 1'b0);
        @(posedge ap_clk);
        #1;
        check_zero_outputs("midreset");
        ap_rst_n = 1'b1;
        repeat (6) @(posedge ap_clk);
        #1;
        check("postreset_count", count, 16'd0);
        check("postreset_tvalid", m_tvalid, 1'b0);
        exp_q.delete();

        // Frame 6: fresh drain after reset
        start_frame();
        wait_done("f6", 3000);
        check("f6_step", md_step, 32'd1);
        check("f6_rx", rx_cnt, NP);
        check("f6_last", last_cnt, 1);
        check("f6_count", count, 16'(NP));
        check("f6_q_empty", exp_q.size(), 0);
`ifdef MD_DRAIN_CHECKSUM_EN
        check("f6_csum", frame_csum, exp_csum);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog
    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
